// File: rtl/record_time_counter.sv
// Elapsed-seconds BCD counter (00-99) for the recorder session display, with time-limit flag.
// Latency: digits, sec_tick and done update on the same edge that ends each counted second; all outputs registered.
// Backpressure: none; start/stop are 1-cycle pulses and hold is a level that pauses counting.
//
// Ports:
//   clock                 system clock (100 MHz)
//   reset                 synchronous, active-high
//   start / stop / hold   session control from the recorder FSM (priority stop > start > hold)
//   limit_tens/limit_ones BCD time limit; 00 or any digit >9 means "no limit"
//   D_1 / D_0             BCD tens/ones of elapsed seconds, straight to the segment display
//   running               high while in RUN
//   sec_tick              1-cycle pulse on each counted second
//   done                  1-cycle pulse when the limit (or saturation at 99) is reached
//
// Build option: define TIMER_WRAP_EN to make the count wrap 99 -> 00 and keep running
// instead of saturating at 99 and flagging done.

module record_time_counter #(
    parameter int TICK_DIV = 100_000_000,   // clock cycles per counted second, >= 2
    parameter int DIV_W    = 27             // prescaler width, 2**DIV_W >= TICK_DIV
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       hold,
    input  logic [3:0] limit_ones,
    input  logic [3:0] limit_tens,
    output logic [3:0] D_0,
    output logic [3:0] D_1,
    output logic       running,
    output logic       sec_tick,
    output logic       done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [DIV_W-1:0] presc;
    logic [DIV_W-1:0] presc_nxt;
    logic [3:0]       ones_nxt;
    logic [3:0]       tens_nxt;
    logic             tick_nxt;
    logic             done_nxt;
    logic             count_en;

    // Incremented BCD value, used only when a second actually elapses.
    logic [3:0] inc_ones;
    logic [3:0] inc_tens;
    logic       limit_valid;
    logic       limit_hit;
    logic       at_max;

    always_comb begin
        inc_ones = D_0;
        inc_tens = D_1;
        if (D_0 >= 4'd9) begin
            inc_ones = 4'd0;
            inc_tens = (D_1 >= 4'd9) ? 4'd0 : D_1 + 4'd1;
        end else begin
            inc_ones = D_0 + 4'd1;
        end
    end

    // A limit with a non-BCD digit can never equal a legal count, so it is treated as absent.
    assign limit_valid = ({limit_tens, limit_ones} != 8'h00) &&
                         (limit_ones <= 4'd9) && (limit_tens <= 4'd9);
    assign limit_hit   = limit_valid && (inc_tens == limit_tens) && (inc_ones == limit_ones);
    assign at_max      = (inc_tens == 4'd9) && (inc_ones == 4'd9);

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        ones_nxt  = D_0;
        tens_nxt  = D_1;
        tick_nxt  = 1'b0;
        done_nxt  = 1'b0;
        count_en  = 1'b0;

        case (state)
            ST_RUN, ST_PAUSE: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (start) begin
                    state_nxt = ST_RUN;
                    presc_nxt = '0;
                    ones_nxt  = 4'd0;
                    tens_nxt  = 4'd0;
                end else if (hold) begin
                    state_nxt = ST_PAUSE;
                end else begin
                    // Releasing hold counts on the same edge, so a second is always
                    // exactly TICK_DIV non-held cycles long.
                    count_en = 1'b1;
                end
            end
            default: begin
                // IDLE and DONE: digits frozen until the next session starts.
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (start) begin
                    state_nxt = ST_RUN;
                    presc_nxt = '0;
                    ones_nxt  = 4'd0;
                    tens_nxt  = 4'd0;
                end
            end
        endcase

        if (count_en) begin
            state_nxt = ST_RUN;
            if (presc == TICK_LAST) begin
                presc_nxt = '0;
                tick_nxt  = 1'b1;
                ones_nxt  = inc_ones;
                tens_nxt  = inc_tens;
                if (limit_hit) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                end
`ifdef TIMER_WRAP_EN
                // 99 -> 00 falls out of the BCD increment; keep counting.
`else
                else if (at_max) begin
                    // Saturate: the display shows 99 and the session ends.
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                end
`endif
            end else begin
                presc_nxt = presc + DIV_W'(1);
            end
        end
    end

`ifdef TIMER_WRAP_EN
    logic unused_at_max;
    assign unused_at_max = at_max;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            presc    <= '0;
            D_0      <= 4'd0;
            D_1      <= 4'd0;
            running  <= 1'b0;
            sec_tick <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            presc    <= presc_nxt;
            D_0      <= ones_nxt;
            D_1      <= tens_nxt;
            running  <= (state_nxt == ST_RUN);
            sec_tick <= tick_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_record_time_counter.sv
module tb_record_time_counter;

    localparam int TD = 4;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       hold;
    logic [3:0] limit_ones;
    logic [3:0] limit_tens;
    logic [3:0] D_0;
    logic [3:0] D_1;
    logic       running;
    logic       sec_tick;
    logic       done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         c;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       dn;
        logic       run;
    } exp_t;

    exp_t q[$];

    record_time_counter #(.TICK_DIV(TD), .DIV_W(8)) dut (
        .clock      (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .hold       (hold),
        .limit_ones (limit_ones),
        .limit_tens (limit_tens),
        .D_0        (D_0),
        .D_1        (D_1),
        .running    (running),
        .sec_tick   (sec_tick),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chkb(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b required=%b (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkd(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_one(input int c, input int n, input bit dn);
        exp_t e;
        e.c    = c;
        e.tens = 4'((n % 100) / 10);
        e.ones = 4'(n % 10);
        e.dn   = dn;
        e.run  = !dn;
        q.push_back(e);
    endtask

    // Tick n of a session whose start was sampled at edge s lands on edge s + TD*n.
    task automatic push_run(input int s, input int first_n, input int last_n, input int done_n);
        for (int n = first_n; n <= last_n; n++)
            push_one(s + TD * n, n, n == done_n);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns on the negedge after the edge that sampled start; s is that edge's index.
    task automatic do_start(output int s);
        @(negedge clk);
        start = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // Monitor: every sec_tick/done must match the next expected event.
    always @(negedge clk) begin
        if (sec_tick === 1'b1 || done === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event cyc=%0d actual tick=%b done=%b D=%h%h required no event",
                         cyc, sec_tick, done, D_1, D_0);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (cyc != e.c || sec_tick !== 1'b1 || D_1 !== e.tens || D_0 !== e.ones ||
                    done !== e.dn || running !== e.run) begin
                    bad++;
                    $display("FAIL tick_event actual cyc=%0d tick=%b D=%h%h done=%b run=%b required cyc=%0d tick=1 D=%h%h done=%b run=%b",
                             cyc, sec_tick, D_1, D_0, done, running, e.c, e.tens, e.ones, e.dn, e.run);
                end
            end
        end
    end

    initial begin
        int s;
        reset = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
        limit_ones = 4'd0; limit_tens = 4'd0;
        wait_cycles(3);
        chkd("reset_digits", {D_1, D_0}, 8'h00);
        chkb("reset_running", running, 1'b0);
        chkb("reset_tick", sec_tick, 1'b0);
        chkb("reset_done", done, 1'b0);
        reset = 1'b0;
        wait_cycles(2);

        // 1: BCD carry 09 -> 10, ten ticks spaced TD apart
        do_start(s);
        push_run(s, 1, 10, -1);
        chkd("t1_start_digits", {D_1, D_0}, 8'h00);
        chkb("t1_running", running, 1'b1);
        wait_cycles(40);
        chkd("t1_digits_10", {D_1, D_0}, 8'h10);
        do_stop();
        chkb("t1_stop_running", running, 1'b0);
        chkd("t1_stop_digits", {D_1, D_0}, 8'h10);

        // 2: limit 03
        limit_tens = 4'd0; limit_ones = 4'd3;
        do_start(s);
        push_run(s, 1, 3, 3);
        wait_cycles(12);
        chkd("t2_digits_03", {D_1, D_0}, 8'h03);
        chkb("t2_done_pulse", done, 1'b1);
        chkb("t2_running_low", running, 1'b0);
        wait_cycles(1);
        chkb("t2_done_one_cycle", done, 1'b0);
        wait_cycles(20);
        chkd("t2_digits_frozen", {D_1, D_0}, 8'h03);
        do_stop();
        limit_ones = 4'd0;

        // 3: hold at prescaler 2 for 10 cycles; tick resumes 2 cycles after release
        do_start(s);
        push_one(s + 14, 1, 1'b0);
        push_one(s + 18, 2, 1'b0);
        wait_cycles(2);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chkb("t3_hold_running", running, 1'b0);
        end
        hold = 1'b0;
        wait_cycles(1);
        chkb("t3_release_running", running, 1'b1);
        chkd("t3_digits_before", {D_1, D_0}, 8'h00);
        wait_cycles(5);
        chkd("t3_digits_02", {D_1, D_0}, 8'h02);
        do_stop();

        // 4: no limit, 400 cycles
        do_start(s);
`ifdef TIMER_WRAP_EN
        push_run(s, 1, 100, -1);
        wait_cycles(400);
        chkd("t4_wrap_digits", {D_1, D_0}, 8'h00);
        chkb("t4_wrap_running", running, 1'b1);
`else
        push_run(s, 1, 99, 99);
        wait_cycles(400);
        chkd("t4_sat_digits", {D_1, D_0}, 8'h99);
        chkb("t4_sat_running", running, 1'b0);
        chkb("t4_sat_done_low", done, 1'b0);
`endif
        do_stop();

        // 5: stop on the edge where tick 2 is due
        do_start(s);
        push_run(s, 1, 1, -1);
        wait_cycles(7);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chkb("t5_no_tick", sec_tick, 1'b0);
        chkd("t5_digits_01", {D_1, D_0}, 8'h01);
        chkb("t5_idle", running, 1'b0);
        wait_cycles(6);
        chkd("t5_idle_frozen", {D_1, D_0}, 8'h01);
        do_start(s);
        chkd("t5_restart_00", {D_1, D_0}, 8'h00);
        push_run(s, 1, 57, -1);

        // 6: reset mid-count at 57, start held during reset
        wait_cycles(228);
        chkd("t6_digits_57", {D_1, D_0}, 8'h57);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chkd("t6_reset_digits", {D_1, D_0}, 8'h00);
        chkb("t6_reset_running", running, 1'b0);
        chkb("t6_reset_done", done, 1'b0);
        wait_cycles(2);
        chkb("t6_start_ignored", running, 1'b0);
        reset = 1'b0;
        start = 1'b0;
        wait_cycles(8);
        chkb("t6_idle_running", running, 1'b0);
        chkd("t6_idle_digits", {D_1, D_0}, 8'h00);

        chkb("queue_drained", q.size() == 0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
